tstate_sequencer: RTL and testbench

Parametrised T-state sequencer for the SAP-2 class MPU, replacing the fixed ring counter plus externally driven early-reset. It generates the one-hot T-state vector that feeds the control matrix. It owns instruction-length termination, memory wait-state stalling, HLT handling and a retired-instruction counter. It sits between the instruction decoder and the control matrix.

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/tstate_sequencer_if.sv | 36 +++
 rtl/tstate_onehot_dec.sv | 21 ++
 rtl/tstate_sequencer.sv | 110 +++++++++++
 tb/tb_tstate_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the SAP-2 class MPU sequencer.
package cpu_ctrl_pkg;

  localparam int unsigned DEF_NUM_T     = 18;
  localparam int unsigned DEF_FETCH_LEN = 3;
  localparam int unsigned DEF_CNT_W     = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seqState_t;

  // Named T-state indices as used by the control matrix.
  localparam int unsigned T0  = 0;
  localparam int unsigned T1  = 1;
  localparam int unsigned T2  = 2;
  localparam int unsigned T3  = 3;
  localparam int unsigned T4  = 4;
  localparam int unsigned T5  = 5;
  localparam int unsigned T6  = 6;
  localparam int unsigned T7  = 7;
  localparam int unsigned T8  = 8;
  localparam int unsigned T9  = 9;
  localparam int unsigned T10 = 10;
  localparam int unsigned T11 = 11;
  localparam int unsigned T12 = 12;
  localparam int unsigned T13 = 13;
  localparam int unsigned T14 = 14;
  localparam int unsigned T15 = 15;
  localparam int unsigned T16 = 16;
  localparam int unsigned T17 = 17;

endpackage

// File: rtl/tstate_sequencer_if.sv
// Decoder <-> sequencer <-> control matrix signal bundle.
interface tstate_sequencer_if
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_T = DEF_NUM_T,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TW    = $clog2(NUM_T)
);

  logic             iStall;
  logic [TW-1:0]    iEndLong;
  logic [TW-1:0]    iEndShort;
  logic             iCondFail;
  logic             iHaltReq;
  logic             iResume;
  logic [NUM_T-1:0] oTstate;
  logic [TW-1:0]    oTindex;
  logic             oFetch;
  logic             oLast;
  logic             oHalted;
  logic             oOverrun;
  logic [CNT_W-1:0] oRetired;

  // Decoder / memory side.
  modport master (
    output iStall, iEndLong, iEndShort, iCondFail, iHaltReq, iResume,
    input  oTstate, oTindex, oFetch, oLast, oHalted, oOverrun, oRetired
  );

  // Sequencer side.
  modport slave (
    input  iStall, iEndLong, iEndShort, iCondFail, iHaltReq, iResume,
    output oTstate, oTindex, oFetch, oLast, oHalted, oOverrun, oRetired
  );

endinterface

// File: rtl/tstate_onehot_dec.sv
// Binary T-index to one-hot T-state decoder with an output enable.
module tstate_onehot_dec #(
  parameter int unsigned NUM_T = 18,
  parameter int unsigned TW    = $clog2(NUM_T)
) (
  input  logic [TW-1:0]    index,
  input  logic             enable,
  output logic [NUM_T-1:0] oneHot
);

  // One bit set at the active index; all zero when disabled.
  always_comb begin
    oneHot = '0;
    for (int unsigned i = 0; i < NUM_T; i++) begin
      if (enable && (index == TW'(i))) begin
        oneHot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tstate_sequencer.sv
// T-state sequencer: instruction-length termination, wait-state stalling,
// HLT handling, overrun flag and retired-instruction counter.
module tstate_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_T     = DEF_NUM_T,
  parameter int unsigned FETCH_LEN = DEF_FETCH_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input logic               iClk,
  input logic               iReset,
  tstate_sequencer_if.slave bus
);

  localparam int unsigned   TW        = $clog2(NUM_T);
  localparam logic [TW-1:0] FETCH_IDX = TW'(FETCH_LEN);
  localparam logic [TW-1:0] LAST_IDX  = TW'(NUM_T - 1);
  localparam logic [TW-1:0] FIRST_IDX = TW'(T0);

  seqState_t        state, stateNext;
  logic [TW-1:0]    tIdx, tIdxNext;
  logic             overrun, overrunNext;
  logic [CNT_W-1:0] retired, retiredNext;
  logic [TW-1:0]    endSel, endEff;
  logic             endValid;
  logic             last;

  // Effective end index. Short ends are raised to the first execute state.
  // An end beyond the last T-state can never be reached: it is left to run
  // into the overrun path rather than retiring at the last state.
  always_comb begin
    endSel   = bus.iCondFail ? bus.iEndShort : bus.iEndLong;
    endEff   = (endSel < FETCH_IDX) ? FETCH_IDX : endSel;
    endValid = (endSel <= LAST_IDX);
  end

  // Next-state, retire and overrun decisions.
  always_comb begin
    stateNext   = state;
    tIdxNext    = tIdx;
    overrunNext = overrun;
    retiredNext = retired;
    last        = 1'b0;
    unique case (state)
      RUN: begin
        if (!bus.iStall) begin
          if ((tIdx == FETCH_IDX) && bus.iHaltReq) begin
            stateNext   = HALT;
            tIdxNext    = FIRST_IDX;
            retiredNext = retired + CNT_W'(1);
          end else if ((tIdx >= FETCH_IDX) && endValid && (tIdx == endEff)) begin
            last        = 1'b1;
            tIdxNext    = FIRST_IDX;
            retiredNext = retired + CNT_W'(1);
          end else if (tIdx == LAST_IDX) begin
            tIdxNext    = FIRST_IDX;
            overrunNext = 1'b1;
          end else begin
            tIdxNext = tIdx + TW'(1);
          end
        end
      end
      HALT: begin
        if (bus.iResume) begin
          stateNext = RUN;
          tIdxNext  = FIRST_IDX;
        end
      end
      default: begin
        stateNext = RUN;
        tIdxNext  = FIRST_IDX;
      end
    endcase
  end

  // State register, counter and sticky overrun flag.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state   <= RUN;
      tIdx    <= FIRST_IDX;
      overrun <= 1'b0;
      retired <= '0;
    end else begin
      state   <= stateNext;
      tIdx    <= tIdxNext;
      overrun <= overrunNext;
      retired <= retiredNext;
    end
  end

  tstate_onehot_dec #(
    .NUM_T (NUM_T),
    .TW    (TW)
  ) uDec (
    .index  (tIdx),
    .enable (state == RUN),
    .oneHot (bus.oTstate)
  );

  // Registered-state views for the decoder and control matrix.
  always_comb begin
    bus.oTindex  = tIdx;
    bus.oFetch   = (state == RUN) && (tIdx < FETCH_IDX);
    bus.oLast    = last;
    bus.oHalted  = (state == HALT);
    bus.oOverrun = overrun;
    bus.oRetired = retired;
  end

endmodule

// File: tb/tb_tstate_sequencer.sv
// Self-checking bench for tstate_sequencer (default parameters).
module tb_tstate_sequencer;

  localparam int unsigned NT = 18;
  localparam int unsigned FL = 3;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tstate_sequencer_if #(.NUM_T(NT), .CNT_W(CW)) bus();

  tstate_sequencer #(
    .NUM_T     (NT),
    .FETCH_LEN (FL),
    .CNT_W     (CW)
  ) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  // One queued cycle: stimulus for that cycle plus the expected outputs.
  typedef struct {
    logic [4:0] idx;
    logic       last;
    logic       halted;
    logic       stall;
    logic       haltReq;
    logic       resume;
  } step_t;

  typedef struct {
    logic [4:0]  endLong;
    logic [4:0]  endShort;
    logic        condFail;
    int unsigned len;
    logic        retire;
    logic        overrun;
  } vec_t;

  step_t       q[$];
  vec_t        vecs[9];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] expRetired;
  logic        expOverrun;
  logic [4:0]  curLong, curShort;
  logic        curCond;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushStep(input logic [4:0] idx, input logic last, input logic halted,
                          input logic stall, input logic haltReq, input logic resume);
    step_t e;
    e.idx = idx; e.last = last; e.halted = halted;
    e.stall = stall; e.haltReq = haltReq; e.resume = resume;
    q.push_back(e);
  endtask

  task automatic pushRun(input int unsigned len, input logic retire);
    for (int unsigned k = 0; k < len; k++)
      pushStep(5'(k), retire && (k == len - 1), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive each queued cycle just after the edge, compare on the falling edge.
  task automatic runQueue;
    step_t       e;
    logic [17:0] oh;
    while (q.size() > 0) begin
      e = q.pop_front();
      bus.iStall   = e.stall;
      bus.iHaltReq = e.haltReq;
      bus.iResume  = e.resume;
      if (!e.halted && (e.idx < 5'(FL))) begin
        bus.iEndLong  = 5'($urandom_range(0, 31));
        bus.iEndShort = 5'($urandom_range(0, 31));
        bus.iCondFail = 1'($urandom_range(0, 1));
      end else begin
        bus.iEndLong  = curLong;
        bus.iEndShort = curShort;
        bus.iCondFail = curCond;
      end
      @(negedge clk);
      oh = '0;
      if (!e.halted) begin
        oh[e.idx] = 1'b1;
        check("tindex", 32'(bus.oTindex), 32'(e.idx));
      end
      check("tstate", 32'(bus.oTstate), 32'(oh));
      check("last",   32'(bus.oLast),   32'(e.last));
      check("fetch",  32'(bus.oFetch),  32'(!e.halted && (e.idx < 5'(FL))));
      check("halted", 32'(bus.oHalted), 32'(e.halted));
      @(posedge clk);
      #1;
    end
    bus.iStall = 1'b0; bus.iHaltReq = 1'b0; bus.iResume = 1'b0;
  endtask

  task automatic checkCounters(input string tag);
    check({tag, "_retired"}, 32'(bus.oRetired), 32'(expRetired));
    check({tag, "_overrun"}, 32'(bus.oOverrun), 32'(expOverrun));
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_tindex"},  32'(bus.oTindex),  32'd0);
    check({tag, "_tstate"},  32'(bus.oTstate),  32'd1);
    check({tag, "_fetch"},   32'(bus.oFetch),   32'd1);
    check({tag, "_halted"},  32'(bus.oHalted),  32'd0);
    check({tag, "_overrun"}, 32'(bus.oOverrun), 32'd0);
    check({tag, "_retired"}, 32'(bus.oRetired), 32'd0);
    check({tag, "_last"},    32'(bus.oLast),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // endLong, endShort, condFail, cycles, retires, sets overrun
    vecs[0] = '{5'd3,  5'd0, 1'b0, 4,  1'b1, 1'b0}; // NOP
    vecs[1] = '{5'd9,  5'd5, 1'b1, 6,  1'b1, 1'b0}; // not-taken path
    vecs[2] = '{5'd9,  5'd5, 1'b0, 10, 1'b1, 1'b0}; // taken path
    vecs[3] = '{5'd0,  5'd0, 1'b0, 4,  1'b1, 1'b0}; // clamped up to T3
    vecs[4] = '{5'd7,  5'd2, 1'b1, 4,  1'b1, 1'b0}; // short end clamped up
    vecs[5] = '{5'd12, 5'd4, 1'b0, 13, 1'b1, 1'b0};
    vecs[6] = '{5'd17, 5'd0, 1'b0, 18, 1'b1, 1'b0}; // ends exactly at T17
    vecs[7] = '{5'd20, 5'd0, 1'b0, 18, 1'b0, 1'b1}; // unreachable end: overrun
    vecs[8] = '{5'd3,  5'd0, 1'b0, 4,  1'b1, 1'b0}; // overrun stays sticky

    rst = 1'b1;
    bus.iStall = 1'b0; bus.iHaltReq = 1'b0; bus.iResume = 1'b0;
    bus.iEndLong = '0; bus.iEndShort = '0; bus.iCondFail = 1'b0;
    curLong = '0; curShort = '0; curCond = 1'b0;
    expRetired = '0; expOverrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst0");
    rst = 1'b0;

    // Table-driven instruction lengths.
    foreach (vecs[i]) begin
      curLong = vecs[i].endLong; curShort = vecs[i].endShort; curCond = vecs[i].condFail;
      pushRun(vecs[i].len, vecs[i].retire);
      runQueue();
      if (vecs[i].retire) expRetired++;
      expOverrun = expOverrun | vecs[i].overrun;
      checkCounters("vec");
    end

    // Wait states: 3 stalls at T4 of a T0..T6 instruction, one at the last state.
    curLong = 5'd6; curShort = 5'd6; curCond = 1'b0;
    for (int k = 0; k < 4; k++) pushStep(5'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pushStep(5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pushStep(5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushStep(5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushStep(5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pushStep(5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runQueue();
    expRetired++;
    checkCounters("stall");

    // HLT at T3: ignored while stalled, then halts; stall toggling has no effect.
    curLong = 5'd5; curShort = 5'd5; curCond = 1'b0;
    for (int k = 0; k < 3; k++) pushStep(5'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushStep(5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pushStep(5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pushStep(5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushStep(5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushStep(5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runQueue();
    expRetired++;
    checkCounters("halt");
    pushStep(5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pushRun(6, 1'b1);
    runQueue();
    expRetired++;
    checkCounters("resume");

    // Asynchronous reset at T7 mid-instruction.
    curLong = 5'd9; curShort = 5'd9; curCond = 1'b0;
    pushRun(7, 1'b0);
    runQueue();
    check("pre_rst_tindex", 32'(bus.oTindex), 32'd7);
    #2 rst = 1'b1;
    #1 checkReset("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    expRetired = '0; expOverrun = 1'b0;
    curLong = 5'd3; curShort = 5'd3;
    pushRun(4, 1'b1);
    runQueue();
    expRetired++;
    checkCounters("post_rst");

    // Asynchronous reset while halted.
    for (int k = 0; k < 3; k++) pushStep(5'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pushStep(5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pushStep(5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runQueue();
    check("pre_rst_halted", 32'(bus.oHalted), 32'd1);
    #2 rst = 1'b1;
    #1 checkReset("rst_halt");
    @(posedge clk);
    #1 rst = 1'b0;
    pushRun(4, 1'b1);
    runQueue();
    expRetired = 16'd1; expOverrun = 1'b0;
    checkCounters("post_rst_halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
